// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch (IF) and load/store (MEM).
// Accesses are sent one byte at a time. Define ARB_RR_EN to use round-robin tie breaking.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        prevIdx;
    logic              tail_q, tail_d;
    logic              isMem_q, isMem_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic              ramWr_q, ramWr_d;
    logic [7:0]        ramDout_q, ramDout_d;
    logic              ifReady_q, ifReady_d;
    logic              memReady_q, memReady_d;
    logic [31:0]       ifData_q, ifData_d;
    logic [31:0]       memRdata_q, memRdata_d;
    logic              busy_q, busy_d;
    logic              grantMem;

    function automatic logic [1:0] lastByteIdx(input logic [1:0] width);
        case (width)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

`ifdef ARB_RR_EN
    // Tracks whether MEM won the previous grant so that a tie goes to the other side.
    logic lastMem_q;
    assign grantMem = mem_req && !(if_req && lastMem_q);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastMem_q <= 1'b0;
        end else if (state_q == IDLE && (mem_req || if_req)) begin
            lastMem_q <= grantMem;
        end
    end
`else
    assign grantMem = mem_req;
`endif

    assign prevIdx = cnt_q - 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            tail_q     <= 1'b0;
            isMem_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramWr_q    <= 1'b0;
            ramDout_q  <= '0;
            ifReady_q  <= 1'b0;
            memReady_q <= 1'b0;
            ifData_q   <= '0;
            memRdata_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            tail_q     <= tail_d;
            isMem_q    <= isMem_d;
            ramAddr_q  <= ramAddr_d;
            ramWr_q    <= ramWr_d;
            ramDout_q  <= ramDout_d;
            ifReady_q  <= ifReady_d;
            memReady_q <= memReady_d;
            ifData_q   <= ifData_d;
            memRdata_q <= memRdata_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        tail_d     = tail_q;
        isMem_d    = isMem_q;
        ramAddr_d  = ramAddr_q;
        ramWr_d    = 1'b0;
        ramDout_d  = ramDout_q;
        ifReady_d  = 1'b0;
        memReady_d = 1'b0;
        ifData_d   = ifData_q;
        memRdata_d = memRdata_q;

        case (state_q)
            IDLE: begin
                if (mem_req || if_req) begin
                    isMem_d   = grantMem;
                    addr_d    = grantMem ? mem_addr : if_addr;
                    wdata_d   = mem_wdata;
                    last_d    = grantMem ? lastByteIdx(mem_width) : 2'd3;
                    cnt_d     = 2'd0;
                    tail_d    = 1'b0;
                    buf_d     = '0;
                    ramAddr_d = addr_d;
                    if (grantMem && mem_wr) begin
                        state_d   = WR;
                        ramWr_d   = 1'b1;
                        ramDout_d = mem_wdata[7:0];
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                // RAM data lags the address by one cycle, so each capture lands one byte behind.
                if (tail_q) begin
                    buf_d[{cnt_q, 3'b000} +: 8] = ram_din;
                    state_d = DONE;
                    if (isMem_q) begin
                        memReady_d = 1'b1;
                        memRdata_d = buf_d;
                    end else begin
                        ifReady_d = 1'b1;
                        ifData_d  = buf_d;
                    end
                end else begin
                    if (cnt_q != 2'd0) begin
                        buf_d[{prevIdx, 3'b000} +: 8] = ram_din;
                    end
                    if (cnt_q == last_q) begin
                        tail_d = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + 2'd1;
                        ramAddr_d = addr_q + ADDR_W'(cnt_d);
                    end
                end
            end
            WR: begin
                if (cnt_q == last_q) begin
                    state_d    = DONE;
                    memReady_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 2'd1;
                    ramAddr_d = addr_q + ADDR_W'(cnt_d);
                    ramWr_d   = 1'b1;
                    ramDout_d = wdata_q[{cnt_d, 3'b000} +: 8];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign if_ready  = ifReady_q;
    assign if_data   = ifData_q;
    assign mem_ready = memReady_q;
    assign mem_rdata = memRdata_q;
    assign ram_addr  = ramAddr_q;
    assign ram_wr    = ramWr_q;
    assign ram_dout  = ramDout_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, arbitration and reset sequences, then random
// accesses checked against a byte-array memory model.
module tb_mem_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_ready;
    logic [31:0]       if_addr, if_data;
    logic              mem_req, mem_wr, mem_ready;
    logic [1:0]        mem_width;
    logic [31:0]       mem_addr, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout, ram_din;
    logic              busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram   [0:65535];
    logic [7:0] model [0:65535];

    typedef struct {
        string       name;
        logic        isMem;
        logic        wr;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        int          expLat;
    } vec_t;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_data(if_data),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .busy(busy)
    );

    function automatic logic [7:0] presetByte(input int i);
        case (i)
            'h1000:  return 8'h13;
            'h1001:  return 8'h00;
            'h1002:  return 8'h00;
            'h1003:  return 8'h93;
            'h0006:  return 8'h5A;
            'h0007:  return 8'hF0;
            'hFFFF:  return 8'h11;
            'h0000:  return 8'h22;
            'h0001:  return 8'h33;
            'h0002:  return 8'h44;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    // Synchronous byte RAM: read data appears one cycle after the address.
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = presetByte(i);
        forever begin
            @(posedge clk);
            if (ram_wr === 1'b1) ram[ram_addr[15:0]] <= ram_dout;
            ram_din <= ram[ram_addr[15:0]];
        end
    end

    function automatic int byteCount(input logic isMem, input logic [1:0] width);
        if (!isMem || width[1]) return 4;
        return (width == 2'd1) ? 2 : 1;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = model[16'(a + 32'(k))];
        return r;
    endfunction

    task automatic modelWrite(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int k = 0; k < n; k++) model[16'(a + 32'(k))] = d[8*k +: 8];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one access from an IDLE negedge; returns at the IDLE negedge after ready.
    task automatic applyStimulus(input logic isMem, input logic wr, input logic [1:0] width,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int lat, output logic [31:0] data, output logic seqOk);
        int   n;
        logic isWr;
        n     = byteCount(isMem, width);
        isWr  = isMem && wr;
        seqOk = (busy === 1'b0);
        lat   = -1;
        data  = '0;
        if (isMem) begin
            mem_req = 1'b1; mem_wr = wr; mem_width = width; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (isMem) begin
                mem_addr = $urandom; mem_wdata = $urandom; mem_width = 2'($urandom); mem_wr = 1'($urandom);
            end else begin
                if_addr = $urandom;
            end
            if (busy !== 1'b1 || (if_ready === 1'b1 && mem_ready === 1'b1)) seqOk = 1'b0;
            if (c <= n) begin
                if (ram_addr !== addr + 32'(c - 1)) seqOk = 1'b0;
                if (isWr && (ram_wr !== 1'b1 || ram_dout !== wdata[8*(c-1) +: 8])) seqOk = 1'b0;
                if (!isWr && ram_wr !== 1'b0) seqOk = 1'b0;
            end else if (c == n + 1 && !isWr && ram_addr !== addr + 32'(n - 1)) begin
                seqOk = 1'b0;
            end
            if ((isMem ? mem_ready : if_ready) === 1'b1) begin
                lat  = c;
                data = isMem ? mem_rdata : if_data;
                if (ram_wr !== 1'b0) seqOk = 1'b0;
                break;
            end
            if ((isMem ? if_ready : mem_ready) !== 1'b0) seqOk = 1'b0;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        if (busy !== 1'b0 || if_ready !== 1'b0 || mem_ready !== 1'b0) seqOk = 1'b0;
    endtask

    // Raises both requests together; reports who was served first and when the second finished.
    task automatic tieRun(output logic firstMem, output int secondLat,
                          output logic [31:0] ifD, output logic [31:0] memD);
        int ifLat, memLat;
        ifLat = -1; memLat = -1; firstMem = 1'bx; ifD = '0; memD = '0;
        if_req = 1'b1; if_addr = 32'h1000;
        mem_req = 1'b1; mem_wr = 1'b0; mem_width = 2'd2; mem_addr = 32'h20;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (if_ready === 1'b1 && mem_ready === 1'b1) checkOutput("tie both ready", 32'd1, 32'd0);
            if (mem_ready === 1'b1 && memLat < 0) begin
                if (ifLat < 0) firstMem = 1'b1;
                memLat = c; memD = mem_rdata; mem_req = 1'b0;
            end
            if (if_ready === 1'b1 && ifLat < 0) begin
                if (memLat < 0) firstMem = 1'b0;
                ifLat = c; ifD = if_data; if_req = 1'b0;
            end
            if (ifLat >= 0 && memLat >= 0) break;
        end
        if_req = 1'b0; mem_req = 1'b0;
        secondLat = (ifLat < 0 || memLat < 0) ? -1 : ((ifLat > memLat) ? ifLat : memLat);
        @(negedge clk);
    endtask

    task automatic resetPulse();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs [11];
        int          lat, ifLat, memLat, n;
        logic [31:0] data, ifD, memD, expIf, expMem;
        logic        seqOk, firstMem, haveIf, haveMem, isMem, wr;
        logic [1:0]  width;
        logic [31:0] addr, wdata;

        vecs[0]  = '{"if word 1000",      1'b0, 1'b0, 2'd2, 32'h0000_1000, 32'h0,          32'h9300_0013, 6};
        vecs[1]  = '{"store word 20",     1'b1, 1'b1, 2'd2, 32'h0000_0020, 32'hDEAD_BEEF,  32'h0,         5};
        vecs[2]  = '{"load byte 7",       1'b1, 1'b0, 2'd0, 32'h0000_0007, 32'h0,          32'h0000_00F0, 3};
        vecs[3]  = '{"load half 6",       1'b1, 1'b0, 2'd1, 32'h0000_0006, 32'h0,          32'h0000_F05A, 4};
        vecs[4]  = '{"load word 20",      1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'h0,          32'hDEAD_BEEF, 6};
        vecs[5]  = '{"store half 40",     1'b1, 1'b1, 2'd1, 32'h0000_0040, 32'h1234_5678,  32'h0,         3};
        vecs[6]  = '{"load word 40",      1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0,          32'hD8D1_5678, 6};
        vecs[7]  = '{"store byte 50",     1'b1, 1'b1, 2'd0, 32'h0000_0050, 32'hFFFF_FFAB,  32'h0,         2};
        vecs[8]  = '{"load half 50",      1'b1, 1'b0, 2'd1, 32'h0000_0050, 32'h0,          32'h0000_3AAB, 4};
        vecs[9]  = '{"load w3 wrap",      1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0,          32'h4433_2211, 6};
        vecs[10] = '{"if word wrap",      1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,          32'h3322_11F5, 6};

        for (int i = 0; i < 65536; i++) model[i] = presetByte(i);

        rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_wr = 1'b0;
        mem_width = '0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset readies", {30'b0, if_ready, mem_ready}, 32'd0);
        checkOutput("reset ram_wr/dout", {23'b0, ram_wr, ram_dout}, 32'd0);
        checkOutput("reset ram_addr", ram_addr, 32'd0);
        checkOutput("reset if_data", if_data, 32'd0);
        checkOutput("reset mem_rdata", mem_rdata, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].isMem, vecs[i].wr, vecs[i].width, vecs[i].addr, vecs[i].wdata, lat, data, seqOk);
            checkOutput({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].expLat));
            checkOutput({vecs[i].name, " bus sequence"}, {31'b0, seqOk}, 32'd1);
            if (vecs[i].isMem && vecs[i].wr)
                modelWrite(vecs[i].addr, byteCount(1'b1, vecs[i].width), vecs[i].wdata);
            else
                checkOutput({vecs[i].name, " data"}, data, vecs[i].expData);
        end

        // MEM request arrives mid IF read; address presented before grant must be the one used.
        ifLat = -1; memLat = -1; ifD = '0; memD = '0;
        if_req = 1'b1; if_addr = 32'h1000;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) if_addr = 32'h0000_BAD0;
            if (c == 2) begin mem_req = 1'b1; mem_wr = 1'b0; mem_width = 2'd2; mem_addr = 32'h0000_BEEF; end
            if (c == 3) mem_addr = 32'h20;
            if (c == 8) begin mem_addr = 32'h0000_1234; mem_width = 2'd0; end
            if (if_ready === 1'b1 && ifLat < 0) begin ifLat = c; ifD = if_data; if_req = 1'b0; end
            if (mem_ready === 1'b1) begin memLat = c; memD = mem_rdata; mem_req = 1'b0; break; end
        end
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checkOutput("midreq if latency", 32'(ifLat), 32'd6);
        checkOutput("midreq if data", ifD, modelRead(32'h1000, 4));
        checkOutput("midreq mem latency", 32'(memLat), 32'd13);
        checkOutput("midreq mem data", memD, modelRead(32'h20, 4));

        // Reset during byte 2 of a store must clear outputs without a clock edge.
        mem_req = 1'b1; mem_wr = 1'b1; mem_width = 2'd2; mem_addr = 32'h300; mem_wdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("pre-reset ram_wr", {31'b0, ram_wr}, 32'd1);
        checkOutput("pre-reset ram_addr", ram_addr, 32'h302);
        rst = 1'b0;
        #1;
        checkOutput("async reset ram_wr/busy/ready", {29'b0, ram_wr, busy, mem_ready}, 32'd0);
        checkOutput("async reset ram_addr", ram_addr, 32'd0);
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post-reset busy", {31'b0, busy}, 32'd0);
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h300, 32'hCAFE_F00D, lat, data, seqOk);
        modelWrite(32'h300, 4, 32'hCAFE_F00D);
        checkOutput("reissued store latency", 32'(lat), 32'd5);
        checkOutput("reissued store sequence", {31'b0, seqOk}, 32'd1);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h300, 32'h0, lat, data, seqOk);
        checkOutput("reissued store readback", data, 32'hCAFE_F00D);

        // Tie breaking: first tie after reset goes to MEM in both modes.
        resetPulse();
        tieRun(firstMem, lat, ifD, memD);
        checkOutput("tie1 first served mem", {31'b0, firstMem}, 32'd1);
        checkOutput("tie1 second ready cycle", 32'(lat), 32'd13);
        checkOutput("tie1 if data", ifD, modelRead(32'h1000, 4));
        checkOutput("tie1 mem data", memD, modelRead(32'h20, 4));
        applyStimulus(1'b1, 1'b0, 2'd0, 32'h7, 32'h0, lat, data, seqOk);
        checkOutput("solo mem load", data, {24'b0, model[16'h7]});
        tieRun(firstMem, lat, ifD, memD);
`ifdef ARB_RR_EN
        checkOutput("tie2 first served mem", {31'b0, firstMem}, 32'd0);
`else
        checkOutput("tie2 first served mem", {31'b0, firstMem}, 32'd1);
`endif
        checkOutput("tie2 second ready cycle", 32'(lat), 32'd13);

        // Random traffic against the byte-array model.
        haveIf = 1'b0; haveMem = 1'b0; expIf = '0; expMem = '0;
        for (int i = 0; i < 40; i++) begin
            isMem = ($urandom_range(0, 3) != 0);
            wr    = isMem && ($urandom_range(0, 1) == 1);
            width = 2'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            n     = byteCount(isMem, width);
            data  = modelRead(addr, n);
            applyStimulus(isMem, wr, width, addr, wdata, lat, ifD, seqOk);
            checkOutput("rand latency", 32'(lat), 32'(wr ? n + 1 : n + 2));
            checkOutput("rand bus sequence", {31'b0, seqOk}, 32'd1);
            if (wr) begin
                modelWrite(addr, n, wdata);
                haveMem = 1'b0;
            end else begin
                checkOutput("rand read data", ifD, data);
                if (isMem) begin expMem = data; haveMem = 1'b1; end
                else begin expIf = data; haveIf = 1'b1; end
            end
            if (haveIf) checkOutput("rand if_data hold", if_data, expIf);
            if (haveMem) checkOutput("rand mem_rdata hold", mem_rdata, expMem);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
